// File: rtl/uart_rx_ext.sv
// Oversampling UART receiver: 16x ticks, 3-sample majority vote, parity/stop/break checks.
// Define UART_RX_FIFO_EN for a show-ahead FIFO output buffer; otherwise a single holding register is used.
module uart_rx_ext #(
  parameter int CLK_FRE     = 50,
  parameter int BAUD_RATE   = 9600,
  parameter int DATA_WIDTH  = 8,
  parameter int PARITY_ON   = 0,
  parameter int PARITY_TYPE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          i_clk_sys,
  input  logic                          i_rst_n,
  input  logic                          i_uart_rx,
  output logic [DATA_WIDTH-1:0]         o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic                          o_parity_err,
  output logic                          o_frame_err,
  output logic                          o_overrun,
  output logic                          o_break,
  input  logic                          i_err_clr,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int DIV   = (CLK_FRE * 1000000) / (BAUD_RATE * 16);
  localparam int DIV_W = $clog2(DIV);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [3:0] LAST_BIT  = 4'(DATA_WIDTH - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic       PAR_EN    = (PARITY_ON != 0);
  localparam logic       PAR_ODD   = (PARITY_TYPE != 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK_WAIT
  } state_t;

  // Line synchroniser and edge detection
  logic [1:0] sync_q;
  logic       rxs;
  logic       rxs_prev_q;
  logic       fall;

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q     <= 2'b11;
      rxs_prev_q <= 1'b1;
    end else begin
      sync_q     <= {sync_q[0], i_uart_rx};
      rxs_prev_q <= sync_q[1];
    end
  end

  assign rxs  = sync_q[1];
  assign fall = rxs_prev_q & ~rxs;

  // Receiver state
  state_t                  state_q, state_d;
  logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
  logic [3:0]              tick_cnt_q, tick_cnt_d;
  logic [1:0]              smp_q, smp_d;
  logic [3:0]              bit_cnt_q, bit_cnt_d;
  logic                    stop_cnt_q, stop_cnt_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    ones_q, ones_d;
  logic                    par_acc_q, par_acc_d;
  logic                    par_bad_q, par_bad_d;
  logic                    armed_q, armed_d;
  logic [3:0]              idle_cnt_q, idle_cnt_d;
  logic                    push_q, push_d;
  logic [DATA_WIDTH-1:0]   push_data_q, push_data_d;
  logic                    push_perr_q, push_perr_d;
  logic                    frame_set_q, frame_set_d;
  logic                    brk_q, brk_d;

  logic tick;
  logic bit_mid;
  logic bit_end;
  logic maj;

  assign tick    = (div_cnt_q == DIV_LAST);
  assign bit_mid = tick && (tick_cnt_q == 4'd9);
  assign bit_end = tick && (tick_cnt_q == 4'd15);
  // Samples from ticks 7 and 8 are held; the tick-9 sample is the live line
  assign maj     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs) | (smp_q[1] & rxs);

  always_comb begin
    state_d     = state_q;
    div_cnt_d   = tick ? '0 : div_cnt_q + DIV_W'(1);
    tick_cnt_d  = tick_cnt_q;
    smp_d       = smp_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    shift_d     = shift_q;
    ones_d      = ones_q;
    par_acc_d   = par_acc_q;
    par_bad_d   = par_bad_q;
    armed_d     = armed_q;
    idle_cnt_d  = idle_cnt_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    push_perr_d = 1'b0;
    frame_set_d = 1'b0;
    brk_d       = 1'b0;

    if (tick && (state_q != ST_IDLE)) begin
      tick_cnt_d = tick_cnt_q + 4'd1;
      if (tick_cnt_q == 4'd7) smp_d[0] = rxs;
      if (tick_cnt_q == 4'd8) smp_d[1] = rxs;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (tick) begin
          if (!rxs) begin
            idle_cnt_d = '0;
          end else if (idle_cnt_q == 4'd15) begin
            armed_d = 1'b1;
          end else begin
            idle_cnt_d = idle_cnt_q + 4'd1;
          end
        end
        if (armed_q && fall) begin
          state_d    = ST_START;
          div_cnt_d  = '0;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          ones_d     = 1'b0;
          par_acc_d  = 1'b0;
          par_bad_d  = 1'b0;
        end
      end

      ST_START: begin
        if (bit_mid && maj) begin
          state_d = ST_IDLE;
        end else if (bit_end) begin
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        if (bit_mid) begin
          shift_d   = {maj, shift_q[DATA_WIDTH-1:1]};
          ones_d    = ones_q | maj;
          par_acc_d = par_acc_q ^ maj;
        end
        if (bit_end) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = PAR_EN ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end

      ST_PARITY: begin
        if (bit_mid) begin
          ones_d    = ones_q | maj;
          par_bad_d = ((par_acc_q ^ maj) != PAR_ODD);
        end
        if (bit_end) state_d = ST_STOP;
      end

      ST_STOP: begin
        if (bit_mid) begin
          if (!maj) begin
            armed_d    = 1'b0;
            idle_cnt_d = '0;
            if (!ones_q) begin
              brk_d   = 1'b1;
              state_d = ST_BREAK_WAIT;
            end else begin
              frame_set_d = 1'b1;
              state_d     = ST_IDLE;
            end
          end else if (stop_cnt_q == LAST_STOP) begin
            // Leave mid stop bit so the next start edge is caught on time
            push_d      = 1'b1;
            push_data_d = shift_q;
            push_perr_d = par_bad_q;
            armed_d     = 1'b1;
            state_d     = ST_IDLE;
          end
        end else if (bit_end) begin
          stop_cnt_d = stop_cnt_q + 1'b1;
        end
      end

      ST_BREAK_WAIT: begin
        if (rxs) begin
          armed_d    = 1'b0;
          idle_cnt_d = '0;
          state_d    = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      div_cnt_q   <= '0;
      tick_cnt_q  <= '0;
      smp_q       <= 2'b11;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= 1'b0;
      shift_q     <= '0;
      ones_q      <= 1'b0;
      par_acc_q   <= 1'b0;
      par_bad_q   <= 1'b0;
      armed_q     <= 1'b1;
      idle_cnt_q  <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      push_perr_q <= 1'b0;
      frame_set_q <= 1'b0;
      brk_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      smp_q       <= smp_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      shift_q     <= shift_d;
      ones_q      <= ones_d;
      par_acc_q   <= par_acc_d;
      par_bad_q   <= par_bad_d;
      armed_q     <= armed_d;
      idle_cnt_q  <= idle_cnt_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      push_perr_q <= push_perr_d;
      frame_set_q <= frame_set_d;
      brk_q       <= brk_d;
    end
  end

  // Output buffer
  logic pop;
  logic wr_en;
  logic overrun_set;

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  full;

  assign full        = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop         = (count_q != '0) && i_ready;
  assign wr_en       = push_q && (!full || pop);
  assign overrun_set = push_q && full && !pop;

  always_ff @(posedge i_clk_sys) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data_q;
  end

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      if (wr_en && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop && !wr_en) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // Memory is not reset, so the head is masked while empty
  assign o_data       = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign o_valid      = (count_q != '0);
  assign o_fifo_count = count_q;
`else
  logic [DATA_WIDTH-1:0] hold_q;
  logic                  valid_q;

  assign pop         = valid_q && i_ready;
  assign wr_en       = push_q && (!valid_q || pop);
  assign overrun_set = push_q && valid_q && !pop;

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold_q  <= '0;
      valid_q <= 1'b0;
    end else if (wr_en) begin
      hold_q  <= push_data_q;
      valid_q <= 1'b1;
    end else if (pop) begin
      valid_q <= 1'b0;
    end
  end

  assign o_data       = hold_q;
  assign o_valid      = valid_q;
  assign o_fifo_count = CNT_W'(valid_q);
`endif

  // Sticky flags: a set in the same cycle as a clear wins
  logic perr_q, ferr_q, ovr_q;

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      perr_q <= (push_q && push_perr_q) | (perr_q & ~i_err_clr);
      ferr_q <= frame_set_q | (ferr_q & ~i_err_clr);
      ovr_q  <= overrun_set | (ovr_q & ~i_err_clr);
    end
  end

  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;
  assign o_overrun    = ovr_q;
  assign o_break      = brk_q;

endmodule

// File: doc/uart_rx_ext.md
# uart_rx_ext

Parametrised, oversampling UART receiver that replaces the single-register receiver in the serial front end. It adds 16x oversampling with 3-sample majority voting, configurable data width, parity and stop bits, and per-frame error reporting. It also detects line breaks and buffers received words in an optional FIFO with a valid/ready output handshake. It sits between the board RX pin and the command parser / SPI-master control logic.

## Interface
- CLK_FRE, 50: system clock in MHz.
- BAUD_RATE, 9600: line rate in bit/s.
- DATA_WIDTH, 8: data bits per frame, legal range 5..9.
- PARITY_ON, 0: 1 = parity bit present.
- PARITY_TYPE, 0: 0 = even, 1 = odd.
- STOP_BITS, 1: number of stop bits, 1 or 2.
- FIFO_DEPTH, 16: FIFO entries, power of two, at least 2. Used only with UART_RX_FIFO_EN.
- i_clk_sys, input, 1: system clock.
- i_rst_n, input, 1: reset, asynchronous, active-low.
- i_uart_rx, input, 1: asynchronous serial line, idle high.
- o_data, output, DATA_WIDTH: head word, LSB first on the line.
- o_valid, output, 1: o_data holds an unread word.
- i_ready, input, 1: consumer accepts o_data when o_valid && i_ready.
- o_parity_err, output, 1: sticky flag; a pushed word had bad parity.
- o_frame_err, output, 1: sticky flag; a stop bit sampled low and the frame was dropped.
- o_overrun, output, 1: sticky flag; a word was dropped because the buffer was full.
- o_break, output, 1: one-cycle pulse on break detection.
- i_err_clr, input, 1: synchronous clear of all sticky flags.
- o_fifo_count, output, $clog2(FIFO_DEPTH)+1: number of buffered words.

## Operation
- **Synchroniser:** i_uart_rx passes through a 2-flop synchroniser (reset value 1). All logic uses the synchronised line, rxs.
- **Tick generator:**
  - DIV = CLK_FRE*1000000/(BAUD_RATE*16), truncated; DIV must be at least 2.
  - One-cycle tick every DIV clocks.
  - The divider and the 4-bit tick counter restart on start-edge detection.
- **State machine:** IDLE, START, DATA, PARITY (PARITY_ON only), STOP, BREAK_WAIT.
- **IDLE:**
  - Arms only after rxs has been seen high for at least 16 ticks, or since reset release.
  - A falling edge of rxs then moves to START.
- **Bit sampling:**
  - Each bit lasts 16 ticks.
  - Samples are taken at ticks 7, 8 and 9; bit value = majority of the three, decided at tick 9.
  - The bit ends at tick 15.
- **START:** majority 1 is a false start and returns to IDLE with no flags set. Otherwise go to DATA.
- **DATA:** shifts in DATA_WIDTH bits, LSB first, then goes to PARITY or STOP.
- **PARITY:**
  - Even: the ones count over data plus parity bit must be even.
  - Odd: that count must be odd.
  - A mismatch marks the frame parity-bad.
- **STOP, decided at tick 9 of each stop bit:**
  - Any stop bit low, with all data (and parity) bits 0: break. Pulse o_break, drop the frame, enter BREAK_WAIT.
  - Any stop bit low otherwise: set o_frame_err, drop the frame, return to IDLE.
  - Last stop bit high: push the word and return to IDLE immediately (mid stop bit), so back-to-back frames resynchronise.
  - A parity-bad word is still pushed and sets o_parity_err.
- **BREAK_WAIT:** stays until rxs is high, then goes to IDLE (armed after 16 high ticks).
- **Sticky flags:** cleared by i_err_clr. A set and a clear in the same cycle: set wins.

## Timing
- **Reset values:**
  - o_data = 0, o_valid = 0, o_fifo_count = 0.
  - All error flags = 0, o_break = 0.
  - State IDLE; synchroniser = 1.
- **Reset mid-frame:** discards the partial frame and the FIFO contents.
- **Latency:** the push occurs at tick 9 of the last stop bit plus 1 clock. o_valid and o_fifo_count update on the clock edge after the push.
- **Pin to o_valid:** at most (1+DATA_WIDTH+PARITY_ON+STOP_BITS-1)*16+9 ticks + 4 clocks after the falling pin edge.
- **Pop:** o_valid && i_ready, effective at the same edge. The next head appears on the following cycle.
- **Push when full:** the word is dropped and o_overrun is set, unless a pop occurs in the same cycle. In that case the push is accepted and the count is unchanged.
- **Push and pop when empty:** the word lands and o_valid goes to 1 on the next cycle; a word is never bypassed in the same cycle.
- **Pointers:** wrap modulo FIFO_DEPTH.

## Configuration
- **UART_RX_FIFO_EN defined:**
  - Show-ahead FIFO of FIFO_DEPTH entries.
  - o_data = head entry; o_valid = (count != 0).
- **UART_RX_FIFO_EN undefined:**
  - Single holding register; FIFO_DEPTH is ignored.
  - o_fifo_count is 0 or 1.
  - A push while o_valid && !i_ready keeps the old word and sets o_overrun.
  - A push in the same cycle as a pop is accepted.

## Test plan
- **Basic frame:** CLK_FRE=50, BAUD_RATE=115200 (DIV=27), 8N1, send 0xA5, i_ready=1 -> one o_valid pulse with o_data=0xA5 and no flags.
- **Glitch rejection:** a 5-tick low glitch on an idle line -> no state change past START, o_valid stays 0, no flags.
- **Parity:** PARITY_ON=1, PARITY_TYPE=1, send 0x03 with parity bit 0 -> 0x03 pushed and o_parity_err=1. Pulse i_err_clr -> flag 0.
- **Framing:** send 0x55 with the stop bit low -> o_frame_err=1, o_fifo_count stays 0. A following valid 0x12 frame -> pushed.
- **Break:** hold the line low for 2 frame times -> exactly one o_break pulse and nothing pushed. Line high for 16 ticks, then 0x7E -> pushed.
- **Overrun (FIFO build, FIFO_DEPTH=4):** i_ready=0, send 5 back-to-back frames 0x01..0x05 -> count=4, o_overrun=1. Then i_ready=1 -> 0x01..0x04 delivered in order.
